// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared types, flag indices and width helpers for the FP adder.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        NORM = 3'd1,
        INF  = 3'd2,
        QNAN = 3'd3,
        SNAN = 3'd4
    } fp_class_e;

    localparam int c_FLAG_INVALID  = 2;
    localparam int c_FLAG_OVERFLOW = 1;
    localparam int c_FLAG_INEXACT  = 0;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to W.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (64'(fp_exp_ones(exp_w)) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Subnormal encodings (exp = 0) classify as ZERO: they are flushed.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero, input logic man_msb);
        fp_class_e cls;
        if (exp_zero)      cls = ZERO;
        else if (!exp_ones) cls = NORM;
        else if (man_zero) cls = INF;
        else if (man_msb)  cls = QNAN;
        else               cls = SNAN;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Brief    : Combinational leading-zero counter; all-zero input gives WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_count
);

    logic w_found;

    always_comb begin
        o_count = CNT_W'(WIDTH);
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && i_vec[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Brief    : Pipelined FP add/sub (input reg + 4 stages), RNE, FTZ, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);

    localparam int c_W         = fp_width(EXP_W, MAN_W);
    localparam int c_SW        = MAN_W + 4;
    localparam int c_LZC_W     = $clog2(MAN_W + 5);
    localparam int c_XW        = ((EXP_W > c_LZC_W) ? EXP_W : c_LZC_W) + 2;
    localparam int c_SPW       = c_W + 4;
    localparam int c_MAX_SHIFT = MAN_W + 3;
    localparam logic [c_W-1:0]   c_QNAN     = c_W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;

    logic w_en;

    // Pipeline registers; special-value bypass word = {is_special, flags[2:0], result}
    logic               r_p0_valid_q, w_p0_valid_d, r_p0_op_q, w_p0_op_d;
    logic [c_W-1:0]     r_p0_a_q, w_p0_a_d, r_p0_b_q, w_p0_b_d;
    logic               r_s1_valid_q, w_s1_valid_d, r_s1_sign_q, w_s1_sign_d;
    logic               r_s1_sub_q, w_s1_sub_d;
    logic [c_SPW-1:0]   r_s1_spec_q, w_s1_spec_d;
    logic [EXP_W-1:0]   r_s1_exp_q, w_s1_exp_d;
    logic [c_SW-1:0]    r_s1_hi_q, w_s1_hi_d, r_s1_lo_q, w_s1_lo_d;
    logic               r_s2_valid_q, w_s2_valid_d, r_s2_sign_q, w_s2_sign_d;
    logic               r_s2_sub_q, w_s2_sub_d;
    logic [c_SPW-1:0]   r_s2_spec_q, w_s2_spec_d;
    logic [EXP_W-1:0]   r_s2_exp_q, w_s2_exp_d;
    logic [c_SW:0]      r_s2_sum_q, w_s2_sum_d;
    logic               r_s3_valid_q, w_s3_valid_d, r_s3_sign_q, w_s3_sign_d;
    logic               r_s3_zero_q, w_s3_zero_d;
    logic [c_SPW-1:0]   r_s3_spec_q, w_s3_spec_d;
    logic [c_XW-1:0]    r_s3_exp_q, w_s3_exp_d;
    logic [c_SW-1:0]    r_s3_norm_q, w_s3_norm_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [c_W-1:0]     r_out_result_q, w_out_result_d;
    logic [2:0]         r_out_flags_q, w_out_flags_d;

    // S1 combinational
    logic               w_sa, w_sb, w_b_larger, w_sign_hi;
    logic [EXP_W-1:0]   w_ea, w_eb, w_e_hi, w_e_lo, w_d;
    logic [MAN_W-1:0]   w_ma, w_mb, w_ma_f, w_mb_f, w_m_hi, w_m_lo;
    fp_class_e          w_cls_a, w_cls_b;
    logic [c_SPW-1:0]   w_spec;
    logic [c_SW-1:0]    w_sig_hi, w_sig_lo, w_sig_al;
    logic               w_sticky;
    int                 w_shamt;
    // S2..S4 combinational
    logic [c_SW:0]      w_sum;
    logic [c_LZC_W-1:0] w_lzc;
    logic [c_SW-1:0]    w_norm;
    logic [c_XW-1:0]    w_exp_n, w_exp_r;
    logic [MAN_W+1:0]   w_mant_r;
    logic [MAN_W-1:0]   w_frac;
    logic               w_g, w_r, w_s, w_rnd_up;
    logic [c_W-1:0]     w_res;
    logic [2:0]         w_flg;

    assign w_en      = !r_out_valid_q || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid_q;
    assign result    = r_out_result_q;
    assign flags     = r_out_flags_q;

    always_comb begin : s1_unpack_align
        w_sa    = r_p0_a_q[c_W-1];
        w_sb    = r_p0_b_q[c_W-1] ^ r_p0_op_q;
        w_ea    = r_p0_a_q[c_W-2:MAN_W];
        w_eb    = r_p0_b_q[c_W-2:MAN_W];
        w_ma    = r_p0_a_q[MAN_W-1:0];
        w_mb    = r_p0_b_q[MAN_W-1:0];
        w_cls_a = fp_classify(w_ea == '0, w_ea == c_EXP_ONES, w_ma == '0, w_ma[MAN_W-1]);
        w_cls_b = fp_classify(w_eb == '0, w_eb == c_EXP_ONES, w_mb == '0, w_mb[MAN_W-1]);

        w_spec = '0;
        if (w_cls_a inside {QNAN, SNAN} || w_cls_b inside {QNAN, SNAN}) begin
            w_spec[c_SPW-1]              = 1'b1;
            w_spec[c_W + c_FLAG_INVALID] = (w_cls_a == SNAN) || (w_cls_b == SNAN);
            w_spec[c_W-1:0]              = c_QNAN;
        end else if (w_cls_a == INF && w_cls_b == INF && w_sa != w_sb) begin
            w_spec[c_SPW-1]              = 1'b1;
            w_spec[c_W + c_FLAG_INVALID] = 1'b1;
            w_spec[c_W-1:0]              = c_QNAN;
        end else if (w_cls_a == INF) begin
            w_spec[c_SPW-1]   = 1'b1;
            w_spec[c_W-1:0]   = {w_sa, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_cls_b == INF) begin
            w_spec[c_SPW-1]   = 1'b1;
            w_spec[c_W-1:0]   = {w_sb, c_EXP_ONES, {MAN_W{1'b0}}};
        end

        // Flushed denormals must not win the magnitude compare on stray mantissa bits
        w_ma_f     = (w_cls_a == ZERO) ? '0 : w_ma;
        w_mb_f     = (w_cls_b == ZERO) ? '0 : w_mb;
        w_b_larger = {w_eb, w_mb_f} > {w_ea, w_ma_f};
        w_sign_hi  = w_b_larger ? w_sb : w_sa;
        w_e_hi     = w_b_larger ? w_eb : w_ea;
        w_e_lo     = w_b_larger ? w_ea : w_eb;
        w_m_hi     = w_b_larger ? w_mb_f : w_ma_f;
        w_m_lo     = w_b_larger ? w_ma_f : w_mb_f;
        w_sig_hi   = (w_e_hi == '0) ? '0 : {1'b1, w_m_hi, 3'b000};
        w_sig_lo   = (w_e_lo == '0) ? '0 : {1'b1, w_m_lo, 3'b000};
        w_d        = w_e_hi - w_e_lo;
        w_shamt    = (int'(w_d) > c_MAX_SHIFT) ? c_MAX_SHIFT : int'(w_d);
        w_sticky   = |(w_sig_lo & ~({c_SW{1'b1}} << w_shamt));
        w_sig_al   = (w_sig_lo >> w_shamt) | {{(c_SW-1){1'b0}}, w_sticky};
    end

    assign w_sum = r_s1_sub_q ? ({1'b0, r_s1_hi_q} - {1'b0, r_s1_lo_q})
                              : ({1'b0, r_s1_hi_q} + {1'b0, r_s1_lo_q});

    fp_lzc #(
        .WIDTH (c_SW),
        .CNT_W (c_LZC_W)
    ) u_lzc (
        .i_vec   (r_s2_sum_q[c_SW-1:0]),
        .o_count (w_lzc)
    );

    always_comb begin : s3_normalise
        if (r_s2_sum_q[c_SW]) begin
            w_norm  = {r_s2_sum_q[c_SW:2], r_s2_sum_q[1] | r_s2_sum_q[0]};
            w_exp_n = c_XW'(r_s2_exp_q) + c_XW'(1);
        end else begin
            w_norm  = r_s2_sum_q[c_SW-1:0] << w_lzc;
            w_exp_n = c_XW'(r_s2_exp_q) - c_XW'(w_lzc);
        end
    end

    always_comb begin : s4_round_pack
        w_g      = r_s3_norm_q[2];
        w_r      = r_s3_norm_q[1];
        w_s      = r_s3_norm_q[0];
        w_rnd_up = w_g && (w_r || w_s || r_s3_norm_q[3]);
        w_mant_r = {1'b0, r_s3_norm_q[c_SW-1:3]} + (MAN_W + 2)'(w_rnd_up);
        w_exp_r  = r_s3_exp_q + c_XW'(w_mant_r[MAN_W+1]);
        w_frac   = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];

        if (r_s3_spec_q[c_SPW-1]) begin
            w_res = r_s3_spec_q[c_W-1:0];
            w_flg = r_s3_spec_q[c_W+2:c_W];
        end else if (r_s3_zero_q) begin
            w_res = {r_s3_sign_q, {(c_W-1){1'b0}}};
            w_flg = 3'b000;
        end else if (r_s3_exp_q[c_XW-1] || r_s3_exp_q == '0) begin
            w_res = {r_s3_sign_q, {(c_W-1){1'b0}}};
            w_flg = 3'b001;
        end else if (w_exp_r >= c_XW'(c_EXP_ONES)) begin
            w_res = {r_s3_sign_q, c_EXP_ONES, {MAN_W{1'b0}}};
            w_flg = 3'b011;
        end else begin
            w_res = {r_s3_sign_q, w_exp_r[EXP_W-1:0], w_frac};
            w_flg = {2'b00, w_g | w_r | w_s};
        end
    end

    // Every stage advances together on w_en, so bubbles travel with the data
    always_comb begin : stage_next
        w_p0_valid_d = r_p0_valid_q;  w_p0_op_d   = r_p0_op_q;
        w_p0_a_d     = r_p0_a_q;      w_p0_b_d    = r_p0_b_q;
        w_s1_valid_d = r_s1_valid_q;  w_s1_sign_d = r_s1_sign_q; w_s1_sub_d = r_s1_sub_q;
        w_s1_spec_d  = r_s1_spec_q;   w_s1_exp_d  = r_s1_exp_q;
        w_s1_hi_d    = r_s1_hi_q;     w_s1_lo_d   = r_s1_lo_q;
        w_s2_valid_d = r_s2_valid_q;  w_s2_sign_d = r_s2_sign_q; w_s2_sub_d = r_s2_sub_q;
        w_s2_spec_d  = r_s2_spec_q;   w_s2_exp_d  = r_s2_exp_q;  w_s2_sum_d = r_s2_sum_q;
        w_s3_valid_d = r_s3_valid_q;  w_s3_sign_d = r_s3_sign_q; w_s3_zero_d = r_s3_zero_q;
        w_s3_spec_d  = r_s3_spec_q;   w_s3_exp_d  = r_s3_exp_q;  w_s3_norm_d = r_s3_norm_q;
        w_out_valid_d = r_out_valid_q; w_out_result_d = r_out_result_q;
        w_out_flags_d = r_out_flags_q;
        if (w_en) begin
            w_p0_valid_d = in_valid;
            if (in_valid) begin
                w_p0_op_d = op;
                w_p0_a_d  = a;
                w_p0_b_d  = b;
            end
            w_s1_valid_d = r_p0_valid_q;  w_s1_sign_d = w_sign_hi;  w_s1_sub_d = w_sa ^ w_sb;
            w_s1_spec_d  = w_spec;        w_s1_exp_d  = w_e_hi;
            w_s1_hi_d    = w_sig_hi;      w_s1_lo_d   = w_sig_al;
            w_s2_valid_d = r_s1_valid_q;  w_s2_sign_d = r_s1_sign_q; w_s2_sub_d = r_s1_sub_q;
            w_s2_spec_d  = r_s1_spec_q;   w_s2_exp_d  = r_s1_exp_q;  w_s2_sum_d = w_sum;
            w_s3_valid_d = r_s2_valid_q;  w_s3_spec_d = r_s2_spec_q;
            w_s3_zero_d  = (r_s2_sum_q == '0);
            w_s3_sign_d  = (r_s2_sum_q == '0 && r_s2_sub_q) ? 1'b0 : r_s2_sign_q;
            w_s3_exp_d   = w_exp_n;       w_s3_norm_d = w_norm;
            w_out_valid_d = r_s3_valid_q; w_out_result_d = w_res;   w_out_flags_d = w_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p0_valid_q <= 1'b0; r_p0_op_q <= 1'b0; r_p0_a_q <= '0; r_p0_b_q <= '0;
            r_s1_valid_q <= 1'b0; r_s1_sign_q <= 1'b0; r_s1_sub_q <= 1'b0;
            r_s1_spec_q  <= '0;   r_s1_exp_q  <= '0;   r_s1_hi_q  <= '0; r_s1_lo_q <= '0;
            r_s2_valid_q <= 1'b0; r_s2_sign_q <= 1'b0; r_s2_sub_q <= 1'b0;
            r_s2_spec_q  <= '0;   r_s2_exp_q  <= '0;   r_s2_sum_q <= '0;
            r_s3_valid_q <= 1'b0; r_s3_sign_q <= 1'b0; r_s3_zero_q <= 1'b0;
            r_s3_spec_q  <= '0;   r_s3_exp_q  <= '0;   r_s3_norm_q <= '0;
            r_out_valid_q <= 1'b0; r_out_result_q <= '0; r_out_flags_q <= '0;
        end else begin
            r_p0_valid_q <= w_p0_valid_d; r_p0_op_q <= w_p0_op_d;
            r_p0_a_q     <= w_p0_a_d;     r_p0_b_q  <= w_p0_b_d;
            r_s1_valid_q <= w_s1_valid_d; r_s1_sign_q <= w_s1_sign_d; r_s1_sub_q <= w_s1_sub_d;
            r_s1_spec_q  <= w_s1_spec_d;  r_s1_exp_q  <= w_s1_exp_d;
            r_s1_hi_q    <= w_s1_hi_d;    r_s1_lo_q   <= w_s1_lo_d;
            r_s2_valid_q <= w_s2_valid_d; r_s2_sign_q <= w_s2_sign_d; r_s2_sub_q <= w_s2_sub_d;
            r_s2_spec_q  <= w_s2_spec_d;  r_s2_exp_q  <= w_s2_exp_d;  r_s2_sum_q <= w_s2_sum_d;
            r_s3_valid_q <= w_s3_valid_d; r_s3_sign_q <= w_s3_sign_d; r_s3_zero_q <= w_s3_zero_d;
            r_s3_spec_q  <= w_s3_spec_d;  r_s3_exp_q  <= w_s3_exp_d;  r_s3_norm_q <= w_s3_norm_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_result_q <= w_out_result_d;
            r_out_flags_q  <= w_out_flags_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Brief    : Directed self-checking bench for single and half precision builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, op = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] a = '0, b = '0, result;
    logic [2:0]  flags;
    logic        h_in_valid = 1'b0, h_op = 1'b0, h_out_ready = 1'b1;
    logic        h_in_ready, h_out_valid;
    logic [15:0] h_a = '0, h_b = '0, h_result;
    logic [2:0]  h_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with out_ready held high; lat counts edges after accept.
    task automatic run32(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                         output logic [31:0] res, output logic [2:0] fl, output int lat);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = result;
        fl  = flags;
        tick();
    endtask

    task automatic case32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic top, input logic [31:0] exp_res, input logic [2:0] exp_fl);
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        run32(ta, tb_, top, res, fl, lat);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_flags"}, 32'(fl), 32'(exp_fl));
        chk({tag, "_lat"}, 32'(lat), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic        so [8];
        logic [31:0] se [8];
        logic [31:0] held;
        logic [31:0] nres;
        logic [2:0]  nfl;
        int          idx, got, n_stall, extra, lat;
        logic        stalled_prev, acc, saw;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        case32("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        case32("sub_equal",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        case32("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        case32("mixed_zero",  32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
        case32("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        case32("above_tie",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001);
        case32("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        case32("inf_minf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        case32("snan",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        case32("qnan",        32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        case32("inf_finite",  32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
        case32("denorm_in",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        case32("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);

        // Backpressure stream with a 3-cycle consumer stall
        sa = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h3FC00000,
               32'hBF800000, 32'h41200000, 32'h3F000000, 32'h42C80000};
        sb = '{32'h3F800000, 32'h40400000, 32'h40400000, 32'h3E800000,
               32'h3F000000, 32'hC0800000, 32'hBF000000, 32'h3F800000};
        so = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        se = '{32'h40000000, 32'h40A00000, 32'h40000000, 32'h3FE00000,
               32'hBF000000, 32'h40C00000, 32'h3F800000, 32'h42CA0000};
        idx = 0; got = 0; n_stall = 0; stalled_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = sa[idx]; b = sb[idx]; op = so[idx];
            end
            #1;
            if (stalled_prev) chk("stall_hold", result, held);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                held = result;
                stalled_prev = 1'b1;
                n_stall++;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("stream_res", result, se[got]);
                chk("stream_flags", 32'(flags), 32'd0);
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd8);
        chk("stall_cycles", 32'(n_stall), 32'd3);
        extra = 0;
        repeat (8) begin
            if (out_valid) extra++;
            tick();
        end
        chk("no_duplicate", 32'(extra), 32'd0);

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        saw = 1'b0;
        repeat (6) begin
            saw = saw | out_valid;
            tick();
        end
        chk("flush_no_valid", 32'(saw), 32'd0);
        run32(32'h40000000, 32'h40000000, 1'b0, nres, nfl, lat);
        chk("post_rst_res", nres, 32'h40800000);
        chk("post_rst_lat", 32'(lat), 32'd4);

        // Half-precision build
        h_a = 16'h3C00; h_b = 16'h3C00; h_op = 1'b0; h_in_valid = 1'b1;
        tick();
        h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("half_res", 32'(h_result), 32'h00004000);
        chk("half_flags", 32'(h_flags), 32'd0);
        chk("half_lat", 32'(lat), 32'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready stream interface. It is the next-generation adder for the core's FPU datapath. Relative to the current single-precision adder it adds:
- configurable exponent and mantissa widths;
- a runtime add/subtract mode;
- round-to-nearest-even;
- special-value handling;
- exception flags;
- backpressure.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all pipeline state
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- op  in  1  0 = a+b, 1 = a−b (sign of b inverted before alignment)
- a, b  in  W  operands {sign, exp, man}
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  W  rounded sum/difference
- flags  out  3  {invalid, overflow, inexact}, qualified by out_valid

## Operation
- Transfer occurs when valid && ready on the same edge.
- Pipeline advance: en = !out_valid || out_ready. in_ready = en.
- All stage registers load only when en=1.
- Bubbles are carried, not collapsed.
- Denormals are flushed to zero:
  - an input with exp=0 is treated as ±0, with its sign kept;
  - a result with biased exp ≤ 0 after normalisation becomes ±0, with inexact=1 if any mantissa bits were nonzero.
- Specials, resolved in S1 and carried as a bypass to S4:
  - any NaN operand gives canonical qNaN {0, all-ones exp, 1'b1, zeros}. invalid=1 only for signalling NaN (mantissa MSB=0).
  - +inf + −inf (after op applied) gives qNaN, invalid=1.
  - inf with finite gives that inf, flags 0.
- Exact zero result:
  - +0 when the effective signs differ;
  - the common sign when the signs are equal (−0 + −0 = −0).
- Datapath widths:
  - significand is MAN_W+1 bits (hidden 1) plus guard, round and sticky bits (MAN_W+4);
  - sum register is MAN_W+5 bits (carry-out).
- S1 — unpack, classify, magnitude compare and align:
  - magnitude compare is on {exp, man}; the larger operand sets the result sign and exponent;
  - alignment shift d = exp_hi − exp_lo, saturated at MAN_W+3;
  - bits shifted out OR into sticky.
- S2 — add or subtract:
  - effective subtract when sign_a ≠ (sign_b ^ op);
  - subtract is always larger − smaller, so no negative result.
- S3 — normalise:
  - if carry is set, shift right 1 (sticky preserved) and exp+1;
  - otherwise left-shift by the leading-zero count lzc and exp−lzc;
  - an all-zero sum gives the exact-zero rule.
- S4 — round, pack and report:
  - round to nearest, ties to even, using guard/round/sticky;
  - rounding carry renormalises (exp+1);
  - exp ≥ 2^EXP_W−1 gives ±inf with overflow=1 and inexact=1;
  - inexact = G|R|S of the final shift.

## Timing
- Latency: 4 cycles from accepting edge to out_valid high, with out_ready held 1.
- Throughput: 1 result per cycle.
- Reset values: out_valid=0, result=0, flags=0, all internal stage-valid bits 0.
- in_ready is combinational from out_valid/out_ready only; it is 1 in the cycle after reset deasserts.
- Stall:
  - out_valid=1 && out_ready=0 freezes every stage;
  - result and flags hold stable until accepted;
  - in_ready=0 during the stall.
- Simultaneous accept and produce in the same cycle is legal and loses nothing.
- Reset mid-stream discards all in-flight operations; no out_valid follows from pre-reset inputs.
- op, a and b are sampled only on the accepting edge.

## Structure
- Package fp_pkg holds:
  - bias/width helper functions: W, BIAS, exp all-ones;
  - canonical qNaN constant builder;
  - operand class enum {ZERO, NORM, INF, QNAN, SNAN};
  - flag-index localparams.
- Sub-module fp_lzc:
  - parametrised combinational leading-zero counter over MAN_W+4 bits;
  - output width clog2(MAN_W+5);
  - used by S3.
- Stage registers live in fp_addsub_pipe. Expected size is about 250 lines.

## Test plan
- 0x3F800000 + 0x40000000, op=0 → 0x40400000, flags 000, exactly 4 cycles later.
- 0x3F800000 − 0x3F800000 (op=1) → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- Tie and just-above-tie:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1 (tie to even);
  - 0x3F800000 + 0x33800001 → 0x3F800001, inexact=1.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 011;
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, flags 100;
  - 0x7F800001 + 1.0 → 0x7FC00000, invalid=1.
- Backpressure: stream 8 random operand pairs with out_ready low for 3 cycles mid-stream → all 8 results, in order, matching the reference model, none duplicated; result stable throughout the stall.
- Parameter sweep EXP_W=5, MAN_W=10 (half): 0x3C00 + 0x3C00 → 0x4000. Also assert reset with 3 ops in flight → out_valid stays 0 until new inputs have had 4 cycles.
